four_bank_mem: RTL and testbench
================================

FOUR_BANK_MEM -- requirements
Module: four_bank_mem

Interface
REQ-001 Parameter MEM_AW, default 13, word-address bits per bank; each bank holds 2^MEM_AW 16-bit words.
REQ-002 Parameter RD_LAT, default 2, cycles from accepted read to data_out valid; legal range 1..3.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port addr  input  16  byte address; addr[2:1] = bank, addr[15:3] = row, addr[0] = byte bit.
REQ-006 Port data_in  input  16  write data.
REQ-007 Port wr  input  1  write request this cycle.
REQ-008 Port rd  input  1  read request this cycle.
REQ-009 Port data_out  output  16  read data; 16'h0000 when data_valid=0.
REQ-010 Port data_valid  output  1  data_out carries read data this cycle.
REQ-011 Port stall  output  1  combinational; the request in this cycle is rejected.
REQ-012 Port busy  output  4  per-bank busy flags, one bit per bank.
REQ-013 Port err  output  1  registered; illegal request seen last cycle.

Function
REQ-014 A request (rd^wr) in cycle N to bank b SHALL be accepted iff busy[b]=0 and no error condition applies; otherwise stall=1 in cycle N and no state changes.
REQ-015 rd&wr in the same cycle SHALL be rejected: stall=1, err=1 in N+1, no array access.
REQ-016 An accepted write SHALL update the array at the clock edge ending cycle N.
REQ-017 An accepted read SHALL sample the array at the edge ending N and present it on data_out with data_valid=1 in exactly cycle N+RD_LAT, for one cycle only.
REQ-018 Read pipeline SHALL hold up to 4 outstanding reads (one per bank); outputs SHALL emerge in issue order.
REQ-019 Each bank SHALL own a 2-bit busy counter, loaded with 3 on acceptance; busy[b]=1 while the counter is non-zero; the bank is thus unavailable in cycles N+1..N+3.
REQ-020 Back-to-back requests to four different banks in consecutive cycles SHALL all be accepted with no stall.
REQ-021 A request to bank b in cycle N+4 after an accept in cycle N SHALL be accepted.
REQ-022 Read of a location written by an earlier accepted write SHALL return the new data; same-bank ordering is enforced by busy.
REQ-023 The idle cycle (rd=wr=0) SHALL produce stall=0, leave busy counters decrementing, and set err=0 next cycle.
REQ-024 err SHALL be 1 for exactly one cycle per illegal request.

Reset
REQ-025 With rst_n=0 at a rising edge: busy=4'b0000, all counters 0, read pipeline flushed, data_valid=0, data_out=16'h0000, err=0.
REQ-026 Reads in flight when reset asserts SHALL be discarded and never produce data_valid.
REQ-027 Array contents SHALL NOT be altered by reset.
REQ-028 Requests presented while rst_n=0 SHALL be ignored; stall SHALL be 0 during reset.

Configuration
REQ-029 Macro FOUR_BANK_MEM_ALIGN_CHK_EN defined: a request with addr[0]=1 SHALL be rejected (stall=1, err=1 next cycle, no access, no busy load).
REQ-030 Macro undefined: addr[0] SHALL be ignored and odd addresses SHALL be treated as the even address below.

Verification
REQ-031 Reset, write 16'hBEEF to 16'h0008 (cycle 1), read 16'h0008 in cycle 5 -> data_valid=1, data_out=16'hBEEF in cycle 7.
REQ-032 Reads to 16'h0100, 0102, 0104, 0106 in cycles 1-4 -> stall=0 throughout; four data_valid pulses in cycles 3-6 in issue order.
REQ-033 Read 16'h0010 in cycle 1, read 16'h0018 (same bank 0) in cycle 2 -> stall=1 in cycle 2, busy=4'b0001 in cycles 2-4, retry in cycle 5 accepted.
REQ-034 rd=wr=1 at 16'h0020 -> stall=1, err=1 next cycle, array unchanged on a later read.
REQ-035 Read accepted in cycle 1, rst_n=0 in cycle 2 -> no data_valid in cycle 3, busy=0 in cycle 3.
REQ-036 With FOUR_BANK_MEM_ALIGN_CHK_EN, write to 16'h0003 -> stall=1, err=1; without the macro -> the write lands at 16'h0002.

Source files
------------

// File: rtl/four_bank_mem_if.sv
// ---------------------------------------------------------------------------
// four_bank_mem_if
//   Request/response bundle for the four-bank word memory.
//
//   Signals
//     addr        byte address: [2:1] bank, [15:3] row, [0] byte bit
//     data_in     write data
//     wr, rd      write / read request for this cycle
//     data_out    read data, zero whenever data_valid is low
//     data_valid  data_out carries read data this cycle
//     stall       the request presented this cycle is rejected (combinational)
//     busy        one flag per bank, set while that bank is recovering
//     err         an illegal request was seen in the previous cycle
//
//   Modports
//     master  drives requests and observes responses (testbench / client)
//     slave   the memory itself
// ---------------------------------------------------------------------------
interface four_bank_mem_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        data_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, data_valid, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, data_valid, stall, busy, err
  );
endinterface

// File: rtl/four_bank_mem.sv
// ---------------------------------------------------------------------------
// four_bank_mem
//   Four interleaved banks of 16-bit words. The bank is picked by addr[2:1]
//   and the row by addr[15:3]. Each accepted request makes its bank
//   unavailable for the next three cycles; requests to other banks keep
//   flowing, so four banks can be hit back to back. Reads come out of a
//   fixed-latency pipeline in issue order.
//
//   Parameters
//     MEM_AW  word-address bits per bank (1..13), 2^MEM_AW words per bank
//     RD_LAT  cycles from accepted read to data_valid (1..3)
//
//   Ports
//     clk     rising-edge clock
//     rst_n   synchronous active-low reset (array contents are kept)
//     bus     four_bank_mem_if.slave request/response bundle
//
//   Build option
//     FOUR_BANK_MEM_ALIGN_CHK_EN  when defined, odd byte addresses are
//     rejected as illegal; otherwise addr[0] is ignored.
// ---------------------------------------------------------------------------
module four_bank_mem #(
  parameter int MEM_AW = 13,
  parameter int RD_LAT = 2
) (
  input logic            clk,
  input logic            rst_n,
  four_bank_mem_if.slave bus
);

  localparam int IW    = MEM_AW + 2;
  localparam int DEPTH = 2 ** IW;

  logic [1:0]        bankSel;
  logic [12:0]       rowFull;
  logic [MEM_AW-1:0] rowSel;
  logic [IW-1:0]     wordIdx;
  logic [3:0]        busyVec;
  logic              reqAny;
  logic              misalign;
  logic              illegal;
  logic              bankBusy;
  logic              accept;
  logic              acceptRd;
  logic              acceptWr;
  logic [15:0]       rdWord;

  logic [15:0] memArray [DEPTH];

  logic [1:0]  busyCnt_q [4];
  logic [1:0]  busyCnt_d [4];
  logic        err_q;
  logic        err_d;
  logic        pipeValid_q [RD_LAT];
  logic        pipeValid_d [RD_LAT];
  logic [15:0] pipeData_q  [RD_LAT];
  logic [15:0] pipeData_d  [RD_LAT];

  // Address decode: the bank bits sit just above the byte bit so that
  // consecutive words land in different banks.
  assign bankSel = bus.addr[2:1];
  assign rowFull = bus.addr[15:3];
  assign rowSel  = rowFull[MEM_AW-1:0];
  assign wordIdx = {bankSel, rowSel};

`ifdef FOUR_BANK_MEM_ALIGN_CHK_EN
  assign misalign = bus.addr[0];
`else
  // Odd addresses simply alias the even word below them.
  logic unusedAddrBit;
  assign misalign      = 1'b0;
  assign unusedAddrBit = bus.addr[0];
`endif

  // Busy flags are just "counter not yet drained" for each bank.
  always_comb begin
    busyVec = '0;
    for (int b = 0; b < 4; b++) begin
      busyVec[b] = (busyCnt_q[b] != 2'd0);
    end
  end

  // Request classification. rd and wr together, or a misaligned address,
  // is illegal no matter whether the bank is free; a legal request only
  // stalls when its bank is still busy. Nothing is accepted in reset.
  assign reqAny   = bus.rd | bus.wr;
  assign illegal  = (bus.rd & bus.wr) | misalign;
  assign bankBusy = busyVec[bankSel];
  assign accept   = rst_n & reqAny & ~illegal & ~bankBusy;
  assign acceptRd = accept & bus.rd;
  assign acceptWr = accept & bus.wr;
  assign rdWord   = memArray[wordIdx];

  assign bus.stall = rst_n & reqAny & (illegal | bankBusy);
  assign bus.busy  = busyVec;
  assign bus.err   = err_q;

  // Next-state for the per-bank recovery counters and the error flag.
  // The accepted bank reloads to 3, all others drain towards zero.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      busyCnt_d[b] = busyCnt_q[b];
      if (accept && (bankSel == b[1:0])) begin
        busyCnt_d[b] = 2'd3;
      end else if (busyCnt_q[b] != 2'd0) begin
        busyCnt_d[b] = busyCnt_q[b] - 2'd1;
      end
    end
    err_d = reqAny & illegal;
  end

  // Read pipeline next-state: stage 0 captures the array word at the edge
  // that accepts the read, later stages just shift. One read enters per
  // cycle at most, so ordering is preserved for free.
  always_comb begin
    pipeValid_d[0] = acceptRd;
    pipeData_d[0]  = acceptRd ? rdWord : 16'h0000;
    for (int i = 1; i < RD_LAT; i++) begin
      pipeValid_d[i] = pipeValid_q[i-1];
      pipeData_d[i]  = pipeData_q[i-1];
    end
  end

  // Control state register. Reset drops counters, the error flag and any
  // reads still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 4; b++) begin
        busyCnt_q[b] <= 2'd0;
      end
      for (int i = 0; i < RD_LAT; i++) begin
        pipeValid_q[i] <= 1'b0;
        pipeData_q[i]  <= 16'h0000;
      end
      err_q <= 1'b0;
    end else begin
      busyCnt_q   <= busyCnt_d;
      pipeValid_q <= pipeValid_d;
      pipeData_q  <= pipeData_d;
      err_q       <= err_d;
    end
  end

  // The storage array has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (acceptWr) begin
      memArray[wordIdx] <= bus.data_in;
    end
  end

  assign bus.data_valid = pipeValid_q[RD_LAT-1];
  assign bus.data_out   = pipeValid_q[RD_LAT-1] ? pipeData_q[RD_LAT-1] : 16'h0000;

endmodule

// File: tb/tb_four_bank_mem.sv
// ---------------------------------------------------------------------------
// tb_four_bank_mem
//   Drives four_bank_mem through a directed table of per-cycle vectors and
//   then a randomized run compared against a timestamp-based model.
//   Honours FOUR_BANK_MEM_ALIGN_CHK_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_four_bank_mem;
  localparam int RD_LAT = 2;
`ifdef FOUR_BANK_MEM_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  four_bank_mem_if bus();

  four_bank_mem #(.MEM_AW(13), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        rstN;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] din;
    logic        eStall;
    logic [3:0]  eBusy;
    logic        eErr;
    logic        eValid;
    logic [15:0] eData;
  } vec_t;

  typedef struct {
    int          due;
    bit          known;
    logic [15:0] data;
  } rdq_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: the cycle each bank was last accepted in, the
  // cycle an err pulse is owed in, pending reads and known memory words.
  int          cycleNo;
  int          lastAcc [4];
  int          errAt;
  rdq_t        rdQ[$];
  logic [15:0] memModel [int];

  function automatic vec_t mk(input logic rstN, input logic rd, input logic wr,
                              input logic [15:0] addr, input logic [15:0] din,
                              input logic eStall, input logic [3:0] eBusy,
                              input logic eErr, input logic eValid,
                              input logic [15:0] eData);
    vec_t v;
    v.rstN = rstN; v.rd = rd; v.wr = wr; v.addr = addr; v.din = din;
    v.eStall = eStall; v.eBusy = eBusy; v.eErr = eErr;
    v.eValid = eValid; v.eData = eData;
    return v;
  endfunction

  function automatic vec_t mkIdle(input logic [3:0] eBusy, input logic eErr,
                                  input logic eValid, input logic [15:0] eData);
    return mk(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, eBusy, eErr, eValid, eData);
  endfunction

  // Present one cycle of inputs just after the falling edge and let the
  // combinational stall settle before anything is sampled.
  task automatic applyStimulus(input logic rstN, input logic rd, input logic wr,
                               input logic [15:0] addr, input logic [15:0] din);
    @(negedge clk);
    rst_n       = rstN;
    bus.rd      = rd;
    bus.wr      = wr;
    bus.addr    = addr;
    bus.data_in = din;
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at step %0d: actual=%h expected=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    logic        r, w, rs, odd, req, ill, eStall, eErr, eValid, eKnown;
    logic [2:0]  row;
    logic [1:0]  bk;
    logic [15:0] a, d, eData;
    logic [3:0]  eBusy;
    int          op, key;
    rdq_t        ent;

    // ---- directed table: one row per cycle -------------------------------
    tbl.push_back(mk(0,1,0,16'h0008,16'h0000, 0,4'b0000,0,0,16'h0000)); // 0 request in reset
    tbl.push_back(mkIdle(4'b0000,0,0,16'h0000));                        // 1
    tbl.push_back(mk(1,0,1,16'h0008,16'hBEEF, 0,4'b0000,0,0,16'h0000)); // 2 write BEEF
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 3
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 4
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 5
    tbl.push_back(mk(1,1,0,16'h0008,16'h0000, 0,4'b0000,0,0,16'h0000)); // 6 read back
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 7
    tbl.push_back(mkIdle(4'b0001,0,1,16'hBEEF));                        // 8
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 9
    tbl.push_back(mkIdle(4'b0000,0,0,16'h0000));                        // 10
    tbl.push_back(mk(1,0,1,16'h0100,16'h1111, 0,4'b0000,0,0,16'h0000)); // 11 four banks
    tbl.push_back(mk(1,0,1,16'h0102,16'h2222, 0,4'b0001,0,0,16'h0000)); // 12
    tbl.push_back(mk(1,0,1,16'h0104,16'h3333, 0,4'b0011,0,0,16'h0000)); // 13
    tbl.push_back(mk(1,0,1,16'h0106,16'h4444, 0,4'b0111,0,0,16'h0000)); // 14
    tbl.push_back(mk(1,1,0,16'h0100,16'h0000, 0,4'b1110,0,0,16'h0000)); // 15
    tbl.push_back(mk(1,1,0,16'h0102,16'h0000, 0,4'b1101,0,0,16'h0000)); // 16
    tbl.push_back(mk(1,1,0,16'h0104,16'h0000, 0,4'b1011,0,1,16'h1111)); // 17
    tbl.push_back(mk(1,1,0,16'h0106,16'h0000, 0,4'b0111,0,1,16'h2222)); // 18
    tbl.push_back(mkIdle(4'b1110,0,1,16'h3333));                        // 19
    tbl.push_back(mkIdle(4'b1100,0,1,16'h4444));                        // 20
    tbl.push_back(mkIdle(4'b1000,0,0,16'h0000));                        // 21
    tbl.push_back(mk(1,0,1,16'h0010,16'hC010, 0,4'b0000,0,0,16'h0000)); // 22
    tbl.push_back(mk(1,0,1,16'h0002,16'h7002, 0,4'b0001,0,0,16'h0000)); // 23
    tbl.push_back(mkIdle(4'b0011,0,0,16'h0000));                        // 24
    tbl.push_back(mkIdle(4'b0011,0,0,16'h0000));                        // 25
    tbl.push_back(mk(1,0,1,16'h0018,16'hC018, 0,4'b0010,0,0,16'h0000)); // 26
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 27
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 28
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 29
    tbl.push_back(mk(1,1,0,16'h0010,16'h0000, 0,4'b0000,0,0,16'h0000)); // 30 same-bank pair
    tbl.push_back(mk(1,1,0,16'h0018,16'h0000, 1,4'b0001,0,0,16'h0000)); // 31 stalled
    tbl.push_back(mkIdle(4'b0001,0,1,16'hC010));                        // 32
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 33
    tbl.push_back(mk(1,1,0,16'h0018,16'h0000, 0,4'b0000,0,0,16'h0000)); // 34 retry
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 35
    tbl.push_back(mkIdle(4'b0001,0,1,16'hC018));                        // 36
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 37
    tbl.push_back(mkIdle(4'b0000,0,0,16'h0000));                        // 38
    tbl.push_back(mk(1,0,1,16'h0020,16'hD020, 0,4'b0000,0,0,16'h0000)); // 39
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 40
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 41
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 42
    tbl.push_back(mk(1,1,1,16'h0020,16'hFFFF, 1,4'b0000,0,0,16'h0000)); // 43 rd&wr
    tbl.push_back(mkIdle(4'b0000,1,0,16'h0000));                        // 44 err pulse
    tbl.push_back(mkIdle(4'b0000,0,0,16'h0000));                        // 45
    tbl.push_back(mk(1,1,0,16'h0020,16'h0000, 0,4'b0000,0,0,16'h0000)); // 46
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 47
    tbl.push_back(mkIdle(4'b0001,0,1,16'hD020));                        // 48 unchanged
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 49
    tbl.push_back(mk(1,1,0,16'h0008,16'h0000, 0,4'b0000,0,0,16'h0000)); // 50 read then reset
    tbl.push_back(mk(0,0,0,16'h0000,16'h0000, 0,4'b0001,0,0,16'h0000)); // 51
    tbl.push_back(mkIdle(4'b0000,0,0,16'h0000));                        // 52 discarded
    tbl.push_back(mkIdle(4'b0000,0,0,16'h0000));                        // 53
    tbl.push_back(mk(1,1,0,16'h0008,16'h0000, 0,4'b0000,0,0,16'h0000)); // 54 survives reset
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 55
    tbl.push_back(mkIdle(4'b0001,0,1,16'hBEEF));                        // 56
    tbl.push_back(mkIdle(4'b0001,0,0,16'h0000));                        // 57
    tbl.push_back(mkIdle(4'b0000,0,0,16'h0000));                        // 58
    tbl.push_back(mk(1,0,1,16'h0003,16'h0E03, ALIGN,4'b0000,0,0,16'h0000)); // 59 odd addr
    tbl.push_back(mkIdle(ALIGN ? 4'b0000 : 4'b0010, ALIGN,0,16'h0000)); // 60
    tbl.push_back(mkIdle(ALIGN ? 4'b0000 : 4'b0010, 0,0,16'h0000));     // 61
    tbl.push_back(mkIdle(ALIGN ? 4'b0000 : 4'b0010, 0,0,16'h0000));     // 62
    tbl.push_back(mk(1,1,0,16'h0002,16'h0000, 0,4'b0000,0,0,16'h0000)); // 63
    tbl.push_back(mkIdle(4'b0010,0,0,16'h0000));                        // 64
    tbl.push_back(mkIdle(4'b0010,0,1, ALIGN ? 16'h7002 : 16'h0E03));    // 65
    tbl.push_back(mkIdle(4'b0010,0,0,16'h0000));                        // 66
    tbl.push_back(mkIdle(4'b0000,0,0,16'h0000));                        // 67

    $display("[TB] start, align check %0d", ALIGN);

    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

    for (int i = 0; i < int'(tbl.size()); i++) begin
      applyStimulus(tbl[i].rstN, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].din);
      checkOutput("stall", i, {15'h0, bus.stall},      {15'h0, tbl[i].eStall});
      checkOutput("busy",  i, {12'h0, bus.busy},       {12'h0, tbl[i].eBusy});
      checkOutput("err",   i, {15'h0, bus.err},        {15'h0, tbl[i].eErr});
      checkOutput("valid", i, {15'h0, bus.data_valid}, {15'h0, tbl[i].eValid});
      checkOutput("data",  i, bus.data_out,            tbl[i].eData);
    end

    // ---- randomized run against the model --------------------------------
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    cycleNo = 0;
    errAt   = -1;
    for (int b = 0; b < 4; b++) lastAcc[b] = -100;
    rdQ.delete();

    for (int n = 0; n < 800; n++) begin
      rs  = ($urandom_range(0, 39) != 0);
      op  = int'($urandom_range(0, 19));
      r   = ((op >= 4) && (op <= 10)) || (op >= 18);
      w   = (op >= 11);
      row = 3'($urandom_range(0, 7));
      bk  = 2'($urandom_range(0, 3));
      odd = ($urandom_range(0, 3) == 0);
      a   = {10'h000, row, bk, odd};
      d   = 16'($urandom);

      req = r | w;
      ill = (r & w) | (ALIGN & odd);
      for (int b = 0; b < 4; b++) begin
        eBusy[b] = ((cycleNo - lastAcc[b]) >= 1) && ((cycleNo - lastAcc[b]) <= 3);
      end
      eStall = rs & req & (ill | eBusy[bk]);
      eErr   = (errAt == cycleNo);
      eValid = 1'b0;
      eKnown = 1'b1;
      eData  = 16'h0000;
      if (rdQ.size() > 0 && rdQ[0].due == cycleNo) begin
        eValid = 1'b1;
        eKnown = rdQ[0].known;
        eData  = rdQ[0].data;
      end

      applyStimulus(rs, r, w, a, d);
      checkOutput("rnd_stall", n, {15'h0, bus.stall},      {15'h0, eStall});
      checkOutput("rnd_busy",  n, {12'h0, bus.busy},       {12'h0, eBusy});
      checkOutput("rnd_err",   n, {15'h0, bus.err},        {15'h0, eErr});
      checkOutput("rnd_valid", n, {15'h0, bus.data_valid}, {15'h0, eValid});
      if (eKnown) checkOutput("rnd_data", n, bus.data_out, eData);

      if (eValid) void'(rdQ.pop_front());
      if (!rs) begin
        for (int b = 0; b < 4; b++) lastAcc[b] = -100;
        rdQ.delete();
        errAt = -1;
      end else if (req) begin
        if (ill) begin
          errAt = cycleNo + 1;
        end else if (!eBusy[bk]) begin
          key = int'(a[15:1]);
          lastAcc[bk] = cycleNo;
          if (w) begin
            memModel[key] = d;
          end else begin
            ent.due   = cycleNo + RD_LAT;
            ent.known = memModel.exists(key);
            ent.data  = ent.known ? memModel[key] : 16'h0000;
            rdQ.push_back(ent);
          end
        end
      end
      cycleNo++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
